// File: rtl/cdc_pkg.sv
// Shared definitions for the toggle-handshake crossing cells.
package cdc_pkg;
  localparam int SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [1:0] {
    RESYNC   = 2'd0,
    IDLE     = 2'd1,
    WAIT_ACK = 2'd2
  } cdc_state_e;

  // Counter width able to hold max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/cdc_handshake_tx_if.sv
// Source-side bus of the toggle crossing: local valid/ready word input plus the crossing signals.
// IN_VALID/IN_READY: a word moves on any edge where both are high; IN_DATA is sampled on that edge.
interface cdc_handshake_tx_if
  import cdc_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             IN_VALID;
  logic [WIDTH-1:0] IN_DATA;
  logic             IN_READY;
  logic [WIDTH-1:0] DATA_OUT;
  logic             REQ_TGL;
  logic             ACK_TGL;
  logic             DONE;
  logic             TIMEOUT_ERR;
  cdc_state_e       STATE_DBG;

  modport master (
    input  IN_VALID, IN_DATA, ACK_TGL,
    output IN_READY, DATA_OUT, REQ_TGL, DONE, TIMEOUT_ERR, STATE_DBG
  );

  modport slave (
    output IN_VALID, IN_DATA, ACK_TGL,
    input  IN_READY, DATA_OUT, REQ_TGL, DONE, TIMEOUT_ERR, STATE_DBG
  );
endinterface

// File: rtl/cdc_sync_sr.sv
// N-stage single-bit shift-register synchronizer with synchronous active-high reset.
module cdc_sync_sr
  import cdc_pkg::*;
#(
  parameter int N = SYNC_STAGES_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);
  logic [N-1:0] sr;

  always_ff @(posedge CLK) begin
    if (RST) sr <= '0;
    else     sr <= {sr[N-2:0], d};
  end

  assign q = sr[N-1];
endmodule

// File: rtl/cdc_handshake_tx.sv
// Sender end of a two-phase request/acknowledge crossing; holds DATA_OUT while a toggle is outstanding.
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int TIMEOUT     = 0
) (
  input  logic                CLK,
  input  logic                RST,
  cdc_handshake_tx_if.master  bus
);
  localparam logic [1:0] S_RESYNC   = RESYNC;
  localparam logic [1:0] S_IDLE     = IDLE;
  localparam logic [1:0] S_WAIT_ACK = WAIT_ACK;

  localparam int CW  = cnt_width(TIMEOUT);
  localparam int RCW = cnt_width(SYNC_STAGES);
  localparam logic [CW-1:0]  TMAX  = CW'(TIMEOUT);
  localparam logic [RCW-1:0] RLAST = RCW'(SYNC_STAGES);

  logic [1:0]       state;
  logic [RCW-1:0]   rcnt;
  logic [CW-1:0]    tcnt;
  logic [WIDTH-1:0] data_q;
  logic             req_q;
  logic             err_q;
  logic             ack_s;
  logic             ack_match;
  logic             timeout_hit;

  cdc_sync_sr #(.N(SYNC_STAGES)) u_ack_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (bus.ACK_TGL),
    .q   (ack_s)
  );

  assign ack_match   = (ack_s == req_q);
  // Fires on the edge where the counter steps onto TIMEOUT.
  assign timeout_hit = (TIMEOUT != 0) && (state == S_WAIT_ACK) && (tcnt == TMAX - 1'b1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_RESYNC;
      rcnt   <= '0;
      tcnt   <= '0;
      data_q <= '0;
      req_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (timeout_hit) err_q <= 1'b1;
      case (state)
        S_RESYNC: begin
          // Adopt the peer's parity once the synchronizer holds a fresh sample.
          if (rcnt == RLAST) begin
            req_q <= ack_s;
            state <= S_IDLE;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (bus.IN_VALID) begin
            data_q <= bus.IN_DATA;
            req_q  <= ~req_q;
            tcnt   <= '0;
            state  <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (tcnt != TMAX) tcnt <= tcnt + 1'b1;
          if (ack_match) state <= S_IDLE;
        end
        default: state <= S_RESYNC;
      endcase
    end
  end

  assign bus.IN_READY    = (state == S_IDLE);
  assign bus.DONE        = (state == S_WAIT_ACK) && ack_match;
  assign bus.DATA_OUT    = data_q;
  assign bus.REQ_TGL     = req_q;
  assign bus.TIMEOUT_ERR = err_q;
  assign bus.STATE_DBG   = cdc_state_e'(state);
endmodule
